disp_scheduler: RTL and testbench
=================================

# disp_scheduler

Sequences the shared 4-digit seven-segment display between the slot machine's requesters: reel symbols, player balance, and the win celebration blink. Sits between `sm_engine` (symbols, balance BCD, win/spin status) and `seven_seg_disp`, replacing ad-hoc toggle and blink muxing in `top`. Owns all display-mode decisions, hold and blink timers, and per-digit enables.

## Interface
- `BLINK_TICKS`, 25_000_000: clk cycles per blink phase (on or off).
- `BLINK_COUNT`, 6: number of off+on blink pairs per win celebration.
- `BAL_HOLD_TICKS`, 200_000_000: clk cycles the balance view is held before auto-return.
- `clk` in 1: system clock; one clock domain.
- `rst_n` in 1: reset, asynchronous, active-low.
- `sym` in 12: three 4-bit reel symbols, reel 0 in [3:0].
- `bal_bcd` in 16: four BCD balance digits, digit 0 (ones) in [3:0].
- `bal_req` in 1: single-cycle pulse (debounced button) requesting the balance view.
- `win_evt` in 1: single-cycle pulse; a winning spin has settled.
- `spin_active` in 1: level; reels are spinning.
- `disp_data` out 16: nibbles to `seven_seg_disp`.
- `digit_en` out 4: per-digit enable, 1 = lit. `top` inverts for active-low AN.
- `mode` out 2: current state code (SYM=0, BAL=1, WIN_OFF=2, WIN_ON=3).

## Operation
- States: SYM, BAL, WIN_OFF, WIN_ON. All outputs registered.
- Reset values: state SYM, `disp_data`=16'h0000, `digit_en`=4'b0000, `mode`=0, all timers and counters 0. First post-reset cycle loads the SYM view.
- **SYM:** `disp_data`={4'h0,`sym`}, `digit_en`=4'b0111.
  - `win_evt` -> WIN_OFF, blink pair counter = BLINK_COUNT.
  - Otherwise `bal_req` with `spin_active`=0 -> BAL, hold timer = BAL_HOLD_TICKS.
  - `bal_req` while `spin_active`=1 is dropped.
- **BAL:** `disp_data`=`bal_bcd`, `digit_en` per Configuration.
  - Exit to SYM on hold-timer expiry, on a second `bal_req`, or when `spin_active`=1 (preempt same cycle as sampled).
  - `win_evt` -> WIN_OFF.
- **WIN_OFF:** `digit_en`=4'b0000, `disp_data` holds the SYM view.
  - After BLINK_TICKS cycles -> WIN_ON.
- **WIN_ON:** SYM view, `digit_en`=4'b0111.
  - After BLINK_TICKS cycles, decrement the pair counter.
  - Counter reaches 0 -> SYM; otherwise -> WIN_OFF.
- **Either WIN state:**
  - `spin_active`=1 -> SYM immediately (abort).
  - `win_evt` restarts the sequence at WIN_OFF with a full count.
  - `bal_req` is ignored.
- **Priority per cycle:** `spin_active` abort > `win_evt` > `bal_req` > timer expiry.
- **Widths:** timers sized by `$clog2(param+1)`; counters saturate at 0 and never wrap.
- `sym` and `bal_bcd` are sampled every cycle while shown, so live updates pass through.

## Timing
- One-cycle latency from any input to `disp_data`, `digit_en` and `mode`.
- BAL occupancy is exactly BAL_HOLD_TICKS cycles, counted from the first cycle `mode`=1.
- Each blink phase is exactly BLINK_TICKS cycles.
- A full celebration lasts 2·BLINK_COUNT·BLINK_TICKS cycles, then `mode`=0.
- Async reset deassertion mid-sequence: the state returns to SYM and the sequence is not resumed.

## Configuration
- `DISP_LZ_SUPPRESS_EN` defined: in BAL, leading zero digits (3, then 2, then 1) are blanked in `digit_en`; digit 0 is always lit.
  - Example: `bal_bcd`=16'h0042 -> `digit_en`=4'b0011.
- Not defined: BAL shows `digit_en`=4'b1111 regardless of value.

## Structure
- `disp_sched_pkg`: state enum/`mode` encoding, digit-enable constants (EN_SYM=4'b0111, EN_ALL, EN_NONE).
- One sub-module, `tick_timer`: parameterised down-counter with `load`, `load_val`, `expire` pulse.
  - Instantiated twice: hold timer and blink phase timer.
- Blink pair counter and FSM stay in `disp_scheduler`.

## Test plan
Use BLINK_TICKS=4, BLINK_COUNT=2, BAL_HOLD_TICKS=10.
- Reset, `sym`=12'h123 -> `mode`=0, `disp_data`=16'h0123, `digit_en`=4'b0111 one cycle after `rst_n` rises.
- `bal_req` pulse, `bal_bcd`=16'h0042, no further input -> `mode`=1 for exactly 10 cycles, `digit_en`=4'b0011 (4'b1111 without macro), then `mode`=0.
- `win_evt` pulse -> `digit_en` sequence 0000×4, 0111×4, 0000×4, 0111×4, then `mode`=0 (16 cycles total).
- `win_evt` and `bal_req` in the same cycle -> `mode`=2; `bal_req` during blink leaves `mode` in {2,3}.
- In BAL, raise `spin_active` at cycle 3 -> `mode`=0 next cycle; `bal_req` while spinning -> `mode` stays 0.
- Assert `rst_n`=0 mid-WIN_ON -> outputs zero asynchronously; after release `mode`=0 and no blinking resumes.

Source files
------------

// File: rtl/disp_scheduler_pkg.sv
// Shared definitions for the display scheduler: state/mode encoding,
// digit-enable constants and small helpers for counter widths and blanking.
package disp_sched_pkg;

    typedef enum logic [1:0] {
        ST_SYM     = 2'd0,
        ST_BAL     = 2'd1,
        ST_WIN_OFF = 2'd2,
        ST_WIN_ON  = 2'd3
    } state_e;

    localparam logic [3:0] EN_SYM  = 4'b0111;
    localparam logic [3:0] EN_ALL  = 4'b1111;
    localparam logic [3:0] EN_NONE = 4'b0000;

    // Width able to hold 0..n, never narrower than one bit.
    function automatic int cnt_w(input int unsigned n);
        return (n > 0) ? $clog2(n + 1) : 1;
    endfunction

    // Blank zero digits from the top down; digit 0 always stays lit.
    function automatic logic [3:0] lz_digit_en(input logic [15:0] bcd);
        logic [3:0] en;
        if (bcd[15:12] != 4'h0)     en = EN_ALL;
        else if (bcd[11:8] != 4'h0) en = 4'b0111;
        else if (bcd[7:4] != 4'h0)  en = 4'b0011;
        else                        en = 4'b0001;
        return en;
    endfunction

endpackage

// File: rtl/disp_scheduler_if.sv
// Bundle between the slot engine side (master) and the display scheduler (slave):
// requester inputs plus the registered display outputs.
interface disp_scheduler_if;

    logic [11:0] sym;
    logic [15:0] bal_bcd;
    logic        bal_req;
    logic        win_evt;
    logic        spin_active;
    logic [15:0] disp_data;
    logic [3:0]  digit_en;
    logic [1:0]  mode;

    modport master (
        output sym, bal_bcd, bal_req, win_evt, spin_active,
        input  disp_data, digit_en, mode
    );

    modport slave (
        input  sym, bal_bcd, bal_req, win_evt, spin_active,
        output disp_data, digit_en, mode
    );

endinterface

// File: rtl/disp_scheduler_tick_timer.sv
// tick_timer: loadable down-counter that saturates at zero and pulses expire
// on the load_val-th clock edge after a load.
module tick_timer
    import disp_sched_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         expire
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Fires while the last tick of the period is being counted out.
    assign expire = (cnt_q == W'(1));

endmodule

// File: rtl/disp_scheduler.sv
// disp_scheduler: chooses what the shared 4-digit display shows (reel symbols,
// balance, win blink). Optional DISP_LZ_SUPPRESS_EN blanks leading balance zeros.
module disp_scheduler
    import disp_sched_pkg::*;
#(
    parameter int unsigned BLINK_TICKS    = 25_000_000,
    parameter int unsigned BLINK_COUNT    = 6,
    parameter int unsigned BAL_HOLD_TICKS = 200_000_000
) (
    input logic             clk,
    input logic             rst_n,
    disp_scheduler_if.slave bus
);

    localparam int HOLD_W  = cnt_w(BAL_HOLD_TICKS);
    localparam int BLINK_W = cnt_w(BLINK_TICKS);
    localparam int PAIR_W  = cnt_w(BLINK_COUNT);

    localparam logic [HOLD_W-1:0]  HOLD_FULL  = HOLD_W'(BAL_HOLD_TICKS);
    localparam logic [BLINK_W-1:0] BLINK_FULL = BLINK_W'(BLINK_TICKS);
    localparam logic [PAIR_W-1:0]  PAIR_FULL  = PAIR_W'(BLINK_COUNT);

    function automatic logic [PAIR_W-1:0] pair_sat_dec(input logic [PAIR_W-1:0] v);
        return (v == '0) ? '0 : v - PAIR_W'(1);
    endfunction

    state_e              state_q, state_d;
    logic [PAIR_W-1:0]   pair_q, pair_d, pair_dec;
    logic [15:0]         disp_data_q, disp_data_d;
    logic [3:0]          digit_en_q, digit_en_d;
    logic                win_q;
    logic                hold_load, hold_expire;
    logic [HOLD_W-1:0]   hold_val;
    logic                blink_load_d, blink_expire;
    logic [BLINK_W-1:0]  blink_val;

    assign win_q = (state_q == ST_WIN_OFF) || (state_q == ST_WIN_ON);

    always_comb begin
        state_d      = state_q;
        pair_d       = pair_q;
        blink_load_d = 1'b0;
        pair_dec     = pair_sat_dec(pair_q);

        if (bus.spin_active) begin
            state_d = ST_SYM;
        end else if (bus.win_evt) begin
            state_d      = ST_WIN_OFF;
            pair_d       = PAIR_FULL;
            blink_load_d = 1'b1;
        end else begin
            case (state_q)
                ST_SYM: begin
                    if (bus.bal_req) state_d = ST_BAL;
                end
                ST_BAL: begin
                    if (bus.bal_req || hold_expire) state_d = ST_SYM;
                end
                ST_WIN_OFF: begin
                    if (blink_expire) begin
                        state_d      = ST_WIN_ON;
                        blink_load_d = 1'b1;
                    end
                end
                ST_WIN_ON: begin
                    if (blink_expire) begin
                        pair_d = pair_dec;
                        if (pair_dec == '0) begin
                            state_d = ST_SYM;
                        end else begin
                            state_d      = ST_WIN_OFF;
                            blink_load_d = 1'b1;
                        end
                    end
                end
                default: state_d = ST_SYM;
            endcase
        end

        // Leaving the celebration early clears the phase timer and pair count.
        if (state_d == ST_SYM || state_d == ST_BAL) begin
            pair_d = '0;
            if (win_q) blink_load_d = 1'b1;
        end
    end

    // Hold timer is armed on entry to BAL and cleared on any exit.
    assign hold_load = (state_d == ST_BAL) != (state_q == ST_BAL);
    assign hold_val  = (state_d == ST_BAL) ? HOLD_FULL : '0;
    assign blink_val = (state_d == ST_WIN_OFF || state_d == ST_WIN_ON) ? BLINK_FULL : '0;

    always_comb begin
        disp_data_d = {4'h0, bus.sym};
        digit_en_d  = EN_SYM;
        case (state_d)
            ST_BAL: begin
                disp_data_d = bus.bal_bcd;
`ifdef DISP_LZ_SUPPRESS_EN
                digit_en_d  = lz_digit_en(bus.bal_bcd);
`else
                digit_en_d  = EN_ALL;
`endif
            end
            ST_WIN_OFF: digit_en_d = EN_NONE;
            default:    digit_en_d = EN_SYM;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_SYM;
            pair_q      <= '0;
            disp_data_q <= 16'h0000;
            digit_en_q  <= EN_NONE;
        end else begin
            state_q     <= state_d;
            pair_q      <= pair_d;
            disp_data_q <= disp_data_d;
            digit_en_q  <= digit_en_d;
        end
    end

    tick_timer #(.W(HOLD_W)) u_hold_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (hold_load),
        .load_val (hold_val),
        .expire   (hold_expire)
    );

    tick_timer #(.W(BLINK_W)) u_blink_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (blink_load_d),
        .load_val (blink_val),
        .expire   (blink_expire)
    );

    assign bus.disp_data = disp_data_q;
    assign bus.digit_en  = digit_en_q;
    assign bus.mode      = state_q;

endmodule

// File: tb/tb_disp_scheduler.sv
// Scoreboard bench for disp_scheduler with short timers (blink 4, pairs 2, hold 10).
module tb_disp_scheduler;

    typedef struct packed {
        logic [1:0]  mode;
        logic [3:0]  en;
        logic [15:0] data;
    } exp_t;

`ifdef DISP_LZ_SUPPRESS_EN
    localparam logic [3:0] EN_0042 = 4'b0011;
    localparam logic [3:0] EN_0000 = 4'b0001;
    localparam logic [3:0] EN_0300 = 4'b0111;
    localparam logic [3:0] EN_5000 = 4'b1111;
`else
    localparam logic [3:0] EN_0042 = 4'b1111;
    localparam logic [3:0] EN_0000 = 4'b1111;
    localparam logic [3:0] EN_0300 = 4'b1111;
    localparam logic [3:0] EN_5000 = 4'b1111;
`endif

    logic clk;
    logic rst_n;
    logic [11:0] cur_sym;
    logic [15:0] cur_bcd;

    exp_t  exp_q[$];
    string name_q[$];
    int    n_checks = 0;
    int    n_pass   = 0;

    disp_scheduler_if bus();

    disp_scheduler #(
        .BLINK_TICKS    (4),
        .BLINK_COUNT    (2),
        .BAL_HOLD_TICKS (10)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input exp_t act, input exp_t exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got mode=%0d en=%b data=%h, expected mode=%0d en=%b data=%h",
                     nm, act.mode, act.en, act.data, exp.mode, exp.en, exp.data);
        end
    endtask

    // Monitor: outputs are presented every cycle; compare each against the queue.
    always @(posedge clk) begin
        exp_t  e;
        exp_t  a;
        string nm;
        #1;
        if (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            a  = '{bus.mode, bus.digit_en, bus.disp_data};
            check(nm, a, e);
        end
    end

    // One clock of stimulus plus the output expected right after that edge.
    task automatic cyc(input logic rn, input logic br, input logic we, input logic sa,
                       input logic [1:0] m, input logic [3:0] en, input logic [15:0] d,
                       input string nm);
        @(negedge clk);
        rst_n           = rn;
        bus.sym         = cur_sym;
        bus.bal_bcd     = cur_bcd;
        bus.bal_req     = br;
        bus.win_evt     = we;
        bus.spin_active = sa;
        exp_q.push_back('{m, en, d});
        name_q.push_back(nm);
    endtask

    // Celebration from a win_evt on cycle 0: four-cycle phases OFF, ON, OFF, ON.
    task automatic run_win(input int n, input string nm);
        for (int i = 0; i < n; i++) begin
            logic [1:0] m;
            m = (((i / 4) % 2) == 0) ? 2'd2 : 2'd3;
            cyc(1'b1, 1'b0, (i == 0), 1'b0, m, (m == 2'd2) ? 4'b0000 : 4'b0111,
                16'h0123, nm);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish, got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_t a;
        rst_n           = 1'b0;
        cur_sym         = 12'h123;
        cur_bcd         = 16'h0042;
        bus.sym         = cur_sym;
        bus.bal_bcd     = cur_bcd;
        bus.bal_req     = 1'b0;
        bus.win_evt     = 1'b0;
        bus.spin_active = 1'b0;

        // Reset and first SYM view
        cyc(1'b0, 0, 0, 0, 2'd0, 4'b0000, 16'h0000, "in_reset");
        cyc(1'b0, 0, 0, 0, 2'd0, 4'b0000, 16'h0000, "in_reset");
        cyc(1'b1, 0, 0, 0, 2'd0, 4'b0111, 16'h0123, "post_reset");
        cur_sym = 12'h456;
        cyc(1'b1, 0, 0, 0, 2'd0, 4'b0111, 16'h0456, "sym_live");
        cur_sym = 12'h123;
        cyc(1'b1, 0, 0, 0, 2'd0, 4'b0111, 16'h0123, "sym_idle");

        // Balance view held exactly 10 cycles
        cyc(1'b1, 1, 0, 0, 2'd1, EN_0042, 16'h0042, "bal_enter");
        for (int i = 1; i < 10; i++)
            cyc(1'b1, 0, 0, 0, 2'd1, EN_0042, 16'h0042, "bal_hold");
        cyc(1'b1, 0, 0, 0, 2'd0, 4'b0111, 16'h0123, "bal_expire");

        // Leading-zero patterns with live update, then second bal_req exits
        cur_bcd = 16'h0000;
        cyc(1'b1, 1, 0, 0, 2'd1, EN_0000, 16'h0000, "bal_0000");
        cur_bcd = 16'h0300;
        cyc(1'b1, 0, 0, 0, 2'd1, EN_0300, 16'h0300, "bal_0300");
        cur_bcd = 16'h5000;
        cyc(1'b1, 0, 0, 0, 2'd1, EN_5000, 16'h5000, "bal_5000");
        cyc(1'b1, 1, 0, 0, 2'd0, 4'b0111, 16'h0123, "bal_second_req");
        cur_bcd = 16'h0042;

        // Full celebration, then back to symbols
        run_win(16, "win_full");
        cyc(1'b1, 0, 0, 0, 2'd0, 4'b0111, 16'h0123, "win_done");

        // Simultaneous win_evt/bal_req, bal_req ignored while blinking, spin abort
        cyc(1'b1, 1, 1, 0, 2'd2, 4'b0000, 16'h0123, "win_and_bal");
        cyc(1'b1, 1, 0, 0, 2'd2, 4'b0000, 16'h0123, "bal_in_off");
        cyc(1'b1, 0, 0, 0, 2'd2, 4'b0000, 16'h0123, "win_off");
        cyc(1'b1, 0, 0, 0, 2'd2, 4'b0000, 16'h0123, "win_off");
        cyc(1'b1, 0, 0, 0, 2'd3, 4'b0111, 16'h0123, "win_on");
        cyc(1'b1, 1, 0, 0, 2'd3, 4'b0111, 16'h0123, "bal_in_on");
        cyc(1'b1, 0, 0, 1, 2'd0, 4'b0111, 16'h0123, "spin_abort");
        cyc(1'b1, 0, 0, 0, 2'd0, 4'b0111, 16'h0123, "after_abort");

        // Restart mid WIN_ON gives a full fresh sequence
        run_win(6, "win_pre");
        run_win(16, "win_restart");
        cyc(1'b1, 0, 0, 0, 2'd0, 4'b0111, 16'h0123, "win_restart_done");

        // Spin preempts BAL; bal_req while spinning is dropped
        cyc(1'b1, 1, 0, 0, 2'd1, EN_0042, 16'h0042, "bal_enter2");
        cyc(1'b1, 0, 0, 0, 2'd1, EN_0042, 16'h0042, "bal_c1");
        cyc(1'b1, 0, 0, 0, 2'd1, EN_0042, 16'h0042, "bal_c2");
        cyc(1'b1, 0, 0, 1, 2'd0, 4'b0111, 16'h0123, "bal_spin_preempt");
        cyc(1'b1, 1, 0, 1, 2'd0, 4'b0111, 16'h0123, "bal_req_spinning");
        cyc(1'b1, 0, 0, 0, 2'd0, 4'b0111, 16'h0123, "spin_release");

        // win_evt preempts BAL
        cyc(1'b1, 1, 0, 0, 2'd1, EN_0042, 16'h0042, "bal_enter3");
        cyc(1'b1, 0, 1, 0, 2'd2, 4'b0000, 16'h0123, "bal_to_win");
        cyc(1'b1, 0, 0, 1, 2'd0, 4'b0111, 16'h0123, "win_abort2");

        // Async reset in WIN_ON, no resumption after release
        run_win(6, "win_pre_rst");
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        a = '{bus.mode, bus.digit_en, bus.disp_data};
        check("async_rst", a, '{2'd0, 4'b0000, 16'h0000});
        cyc(1'b0, 0, 0, 0, 2'd0, 4'b0000, 16'h0000, "rst_held");
        cyc(1'b1, 0, 0, 0, 2'd0, 4'b0111, 16'h0123, "post_rst2");
        for (int i = 0; i < 20; i++)
            cyc(1'b1, 0, 0, 0, 2'd0, 4'b0111, 16'h0123, "no_resume");

        repeat (3) @(posedge clk);
        #2;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_pass++;
        end else begin
            $display("FAIL drain: got %0d pending, required 0", exp_q.size());
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
